clk_gen_tap_ctrl: RTL and testbench

Synchronous controller for the tunable ring-oscillator clock generator. It drives the 4-bit select of the tap mux and the enable of the loop NOR gate. On each tap change it quiesces the ring, switches the tap, restarts the ring and, optionally, measures the resulting frequency by counting rising edges of a pre-divided oscillator output over a fixed reference window.

---
 rtl/clk_gen_tap_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_clk_gen_tap_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clk_gen_tap_ctrl.sv
// clk_gen_tap_ctrl
//
// Synchronous controller for the tunable ring-oscillator clock generator.
// A tap change is a fixed sequence:
//   1. Stop the ring.
//   2. Switch the tap mux.
//   3. Restart the ring.
//   4. Optionally measure the new frequency by counting rising edges of the
//      pre-divided oscillator output over a fixed reference window.
//
// Optional feature macro: CLK_GEN_TAP_CTRL_MEAS_EN
//   defined   : MEASURE state, synchronizer and edge counter are built.
//   undefined : START goes straight to DONE, count_o is tied to 0 and
//               osc_div_i is unused.
//
// Parameters:
//   settle_p      cycles spent in each of STOP and START (>= 1)
//   window_p      reference cycles in the measurement window (>= 1)
//   count_width_p width of the edge counter and count_o
//
// Ports:
//   clk_i           reference clock; everything runs on its rising edge
//   reset_i         synchronous active-high reset
//   tap_req_v_i     tap-change request valid
//   tap_req_i       requested tap (0..15)
//   tap_req_ready_o high only in IDLE
//   tap_sel_o       registered tap mux select
//   osc_en_o        registered NOR loop enable (0 quiesces the ring)
//   osc_div_i       divided oscillator output, asynchronous to clk_i
//   count_v_o       one-cycle pulse marking count_o valid
//   count_o         edge count of the last window; held until the next DONE
//   busy_o          high in every state except IDLE

module clk_gen_tap_ctrl #(
    parameter int settle_p      = 16,
    parameter int window_p      = 1024,
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     tap_req_v_i,
    input  logic [3:0]               tap_req_i,
    output logic                     tap_req_ready_o,
    output logic [3:0]               tap_sel_o,
    output logic                     osc_en_o,
    input  logic                     osc_div_i,
    output logic                     count_v_o,
    output logic [count_width_p-1:0] count_o,
    output logic                     busy_o
);

    // One down-counter serves every timed phase, so size it for the longest one.
    localparam int timer_max_lp   = (settle_p > window_p) ? settle_p : window_p;
    localparam int timer_width_lp = $clog2(timer_max_lp + 1);
    localparam logic [timer_width_lp-1:0] settle_load_lp = timer_width_lp'(settle_p - 1);

    typedef enum logic [2:0] {
        IDLE,
        STOP,
        SWITCH,
        START,
        MEASURE,
        DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [timer_width_lp-1:0] timer_q, timer_d;
    logic [3:0]                pend_tap_q, pend_tap_d;
    logic [3:0]                tap_sel_q, tap_sel_d;
    logic                      osc_en_q, osc_en_d;
    logic                      count_v_q, count_v_d;

`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
    localparam logic [timer_width_lp-1:0] window_load_lp = timer_width_lp'(window_p - 1);

    // Layout: sync_q[0] is the first metastability stage,
    // sync_q[1] is the synchronized value, and sync_q[2] holds the
    // previous synchronized value for edge detection.
    logic [2:0]               sync_q, sync_d;
    logic [count_width_p-1:0] cnt_q, cnt_d;
    logic [count_width_p-1:0] count_q, count_d;
    logic                     rise_edge;

    assign sync_d    = {sync_q[1:0], osc_div_i};
    assign rise_edge = sync_q[1] & ~sync_q[2];

    // The synchronizer free-runs (no reset) so it is already settled when
    // a window opens.
    always_ff @(posedge clk_i) begin
        sync_q <= sync_d;
    end
`else
    logic unused_osc_div;
    assign unused_osc_div = osc_div_i;
`endif

    // Next-state logic. Defaults hold every register and keep the pulse
    // low. osc_en only changes on the transitions that stop or start
    // the ring.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pend_tap_d = pend_tap_q;
        tap_sel_d  = tap_sel_q;
        osc_en_d   = osc_en_q;
        count_v_d  = 1'b0;
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
        cnt_d      = cnt_q;
        count_d    = count_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (tap_req_v_i) begin
                    pend_tap_d = tap_req_i;
                    timer_d    = settle_load_lp;
                    osc_en_d   = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    // The mux switches only while the ring is quiet.
                    tap_sel_d = pend_tap_q;
                    state_d   = SWITCH;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            SWITCH: begin
                osc_en_d = 1'b1;
                timer_d  = settle_load_lp;
                state_d  = START;
            end
            START: begin
                if (timer_q == '0) begin
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
                    timer_d = window_load_lp;
                    cnt_d   = '0;
                    state_d = MEASURE;
`else
                    count_v_d = 1'b1;
                    state_d   = DONE;
`endif
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
            MEASURE: begin
                if (rise_edge && (cnt_q != {count_width_p{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (timer_q == '0) begin
                    // Load the updated count so an edge seen in the final
                    // window cycle is still reported.
                    count_d   = cnt_d;
                    count_v_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pend_tap_q <= '0;
            tap_sel_q  <= '0;
            osc_en_q   <= 1'b0;
            count_v_q  <= 1'b0;
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
            cnt_q      <= '0;
            count_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_tap_q <= pend_tap_d;
            tap_sel_q  <= tap_sel_d;
            osc_en_q   <= osc_en_d;
            count_v_q  <= count_v_d;
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
            cnt_q      <= cnt_d;
            count_q    <= count_d;
`endif
        end
    end

    assign tap_req_ready_o = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign tap_sel_o       = tap_sel_q;
    assign osc_en_o        = osc_en_q;
    assign count_v_o       = count_v_q;
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
    assign count_o         = count_q;
`else
    assign count_o         = '0;
`endif

endmodule

// File: tb/tb_clk_gen_tap_ctrl.sv
// Testbench for clk_gen_tap_ctrl.
// Instance A: settle 2, window 8, 16-bit count, osc toggling every 2 cycles.
// Instance B: settle 2, window 32, 3-bit count, osc toggling every cycle.
// Directed sequences with hand-computed expected values.

module tb_clk_gen_tap_ctrl;

    localparam int S  = 2;
    localparam int WA = 8;
    localparam int WB = 32;
`ifdef CLK_GEN_TAP_CTRL_MEAS_EN
    localparam int DONE_A    = 2*S + WA + 2;
    localparam int DONE_B    = 2*S + WB + 2;
    localparam int EXP_CNT_A = 2;
    localparam int EXP_CNT_B = 7;
    localparam int RST_K     = 2*S + 3;
`else
    localparam int DONE_A    = 2*S + 2;
    localparam int DONE_B    = 2*S + 2;
    localparam int EXP_CNT_A = 0;
    localparam int EXP_CNT_B = 0;
    localparam int RST_K     = 2*S + 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_v_a = 1'b0;
    logic [3:0]  req_a = '0;
    logic        req_v_b = 1'b0;
    logic [3:0]  req_b = '0;
    logic [1:0]  osc_cnt = '0;
    logic        osc_a, osc_b;

    logic        ready_a, osc_en_a, count_v_a, busy_a;
    logic [3:0]  tap_sel_a;
    logic [15:0] count_a;
    logic        ready_b, osc_en_b, count_v_b, busy_b;
    logic [3:0]  tap_sel_b;
    logic [2:0]  count_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(negedge clk) osc_cnt <= osc_cnt + 1'b1;
    assign osc_a = osc_cnt[1];
    assign osc_b = osc_cnt[0];

    clk_gen_tap_ctrl #(.settle_p(S), .window_p(WA), .count_width_p(16)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .tap_req_v_i(req_v_a), .tap_req_i(req_a), .tap_req_ready_o(ready_a),
        .tap_sel_o(tap_sel_a), .osc_en_o(osc_en_a), .osc_div_i(osc_a),
        .count_v_o(count_v_a), .count_o(count_a), .busy_o(busy_a)
    );

    clk_gen_tap_ctrl #(.settle_p(S), .window_p(WB), .count_width_p(3)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .tap_req_v_i(req_v_b), .tap_req_i(req_b), .tap_req_ready_o(ready_b),
        .tap_sel_o(tap_sel_b), .osc_en_o(osc_en_b), .osc_div_i(osc_b),
        .count_v_o(count_v_b), .count_o(count_b), .busy_o(busy_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Presents a request at a negedge and returns #1 after the accepting
    // edge T, so the next negedge falls in cycle T+1.
    task automatic applyStimulus(input bit use_b, input logic [3:0] tap);
        @(negedge clk);
        if (use_b) begin
            req_v_b = 1'b1; req_b = tap;
            checkOutput("ready_b_pre", ready_b, 1'b1);
        end else begin
            req_v_a = 1'b1; req_a = tap;
            checkOutput("ready_a_pre", ready_a, 1'b1);
        end
        @(posedge clk);
        #1;
        req_v_a = 1'b0;
        req_v_b = 1'b0;
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_tap"},   tap_sel_a, 4'd0);
        checkOutput({tag, "_osc"},   osc_en_a,  1'b0);
        checkOutput({tag, "_cnt"},   count_a,   16'd0);
        checkOutput({tag, "_cv"},    count_v_a, 1'b0);
        checkOutput({tag, "_ready"}, ready_a,   1'b1);
        checkOutput({tag, "_busy"},  busy_a,    1'b0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkResetA("rst");
        checkOutput("rst_b_ready", ready_b, 1'b1);

        // Full sequence on A with tap 5; count at DONE.
        applyStimulus(1'b0, 4'd5);
        for (int k = 1; k <= DONE_A + 1; k++) begin
            @(negedge clk);
            checkOutput("seq_osc_en",  osc_en_a,  (k >= S + 2));
            checkOutput("seq_tap_sel", tap_sel_a, (k >= S + 1) ? 4'd5 : 4'd0);
            checkOutput("seq_count_v", count_v_a, (k == DONE_A));
            checkOutput("seq_ready",   ready_a,   (k > DONE_A));
            checkOutput("seq_busy",    busy_a,    (k <= DONE_A));
            if (k == DONE_A) checkOutput("seq_count", count_a, EXP_CNT_A);
        end

        // Tap 3 accepted, then tap 9 pulsed while busy must be ignored.
        applyStimulus(1'b0, 4'd3);
        for (int k = 1; k <= DONE_A + 4; k++) begin
            @(negedge clk);
            if (k == 2) begin req_v_a = 1'b1; req_a = 4'd9; end
            if (k == 3) req_v_a = 1'b0;
            checkOutput("busy_tap_sel", tap_sel_a, (k >= S + 1) ? 4'd3 : 4'd5);
            checkOutput("busy_count_v", count_v_a, (k == DONE_A));
            checkOutput("busy_busy",    busy_a,    (k <= DONE_A));
        end

        // Reset in the middle of the sequence.
        applyStimulus(1'b0, 4'd7);
        for (int k = 1; k <= RST_K; k++) @(negedge clk);
        checkOutput("mid_busy_pre", busy_a, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetA("midrst");
        for (int k = 1; k <= DONE_A + 2; k++) begin
            @(negedge clk);
            checkOutput("midrst_count_v", count_v_a, 1'b0);
            checkOutput("midrst_busy",    busy_a,    1'b0);
        end

        // Request coincident with reset is not accepted.
        @(negedge clk);
        reset = 1'b1; req_v_a = 1'b1; req_a = 4'd4;
        @(negedge clk);
        reset = 1'b0; req_v_a = 1'b0;
        @(negedge clk);
        checkOutput("rstreq_busy", busy_a, 1'b0);
        checkOutput("rstreq_tap",  tap_sel_a, 4'd0);

        // Saturating counter on B.
        applyStimulus(1'b1, 4'd12);
        for (int k = 1; k <= DONE_B + 1; k++) begin
            @(negedge clk);
            checkOutput("sat_count_v", count_v_b, (k == DONE_B));
            if (k == DONE_B) checkOutput("sat_count", count_b, EXP_CNT_B);
        end
        checkOutput("sat_tap", tap_sel_b, 4'd12);
        checkOutput("sat_osc", osc_en_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
